// File: rtl/noc_packet_injector.sv
// Buffered, rate-paced packet source feeding one router's in_free input.
// Define NOC_PKT_GEN_EN to build the LFSR traffic generator driven by gen_on.
module noc_packet_injector #(
  parameter int NODES   = 36,
  parameter int ADDR_W  = 6,
  parameter int PAY_W   = 6,
  parameter int DEPTH   = 4,
  parameter int INJ_GAP = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_W-1:0]         node_addr,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_W-1:0]         in_dest,
  input  logic [PAY_W-1:0]          in_payload,
  input  logic                      out_stall,
  output logic [ADDR_W+PAY_W:0]     out_pkt,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic [7:0]                drop_cnt,
  input  logic                      gen_on
);

  localparam int EW = ADDR_W + PAY_W;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int GW = (INJ_GAP > 0) ? $clog2(INJ_GAP + 1) : 1;
  localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
  localparam logic [ADDR_W:0]   NODES_C = (ADDR_W + 1)'(NODES);
  localparam logic [GW-1:0]     GAP_C   = GW'(INJ_GAP);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [EW:0]     pkt_q, pkt_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      drop_q, drop_d;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [EW-1:0]   mem_q [DEPTH];

  logic [ADDR_W-1:0] push_dest;
  logic [PAY_W-1:0]  push_pay;
  logic              push_req;
  logic              reject;
  logic              wr_en;
  logic              pop;
  logic              can_pop;

  assign in_ready = rst_n && (count_q < DEPTH_C);

`ifdef NOC_PKT_GEN_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) lfsr_q <= 16'hACE1;
    else        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_comb begin
    push_dest = in_dest;
    push_pay  = in_payload;
    push_req  = in_valid;
    if (!in_valid && gen_on) begin
      push_dest = lfsr_q[ADDR_W-1:0];
      push_pay  = lfsr_q[EW-1:ADDR_W];
      push_req  = 1'b1;
    end
  end
`else
  logic unused_gen_on;
  assign unused_gen_on = gen_on;

  always_comb begin
    push_dest = in_dest;
    push_pay  = in_payload;
    push_req  = in_valid;
  end
`endif

  assign reject = (push_dest == node_addr) || ({1'b0, push_dest} >= NODES_C);
  assign wr_en  = push_req && in_ready && !reject;

  // Only host pushes count as drops; a rejected generator candidate is just skipped.
  always_comb begin
    drop_d = drop_q;
    if (in_valid && in_ready && reject && (drop_q != 8'hFF))
      drop_d = drop_q + 8'd1;
  end

  assign can_pop = (count_q != '0) && !out_stall;

  // The final GAP cycle (and SEND when INJ_GAP is 0) also makes the IDLE pop
  // decision, so the issue period is exactly 1+INJ_GAP cycles.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pkt_d   = pkt_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (can_pop) begin
          pop     = 1'b1;
          pkt_d   = {1'b1, mem_q[rd_ptr_q]};
          state_d = SEND;
        end
      end
      SEND: begin
        pkt_d = '0;
        if (INJ_GAP == 0) begin
          if (can_pop) begin
            pop     = 1'b1;
            pkt_d   = {1'b1, mem_q[rd_ptr_q]};
            state_d = SEND;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d   = GAP_C;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q <= GW'(1)) begin
          gap_d = '0;
          if (can_pop) begin
            pop     = 1'b1;
            pkt_d   = {1'b1, mem_q[rd_ptr_q]};
            state_d = SEND;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: begin
        pkt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (wr_en && !pop)      count_d = count_q + CW'(1);
    else if (!wr_en && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gap_q    <= '0;
      pkt_q    <= '0;
      count_q  <= '0;
      drop_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      pkt_q   <= pkt_d;
      count_q <= count_d;
      drop_q  <= drop_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {push_dest, push_pay};
  end

  assign out_pkt    = pkt_q;
  assign fifo_count = count_q;
  assign drop_cnt   = drop_q;

endmodule
